// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encodings and parameter defaults.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned RETRY_W = 4;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser bringing a single asynchronous level into the clk domain.
module cdc_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock with bounded
// retries, then releases the downstream reset; drops back on lock loss or soft_rst.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               soft_rst,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_dbg
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  logic               lock_s;
  pll_state_t         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [RETRY_W-1:0] retry_next;
  logic               restart;
  logic               pll_rst_next, sys_rst_n_next, fail_next, lock_lost_next;

  cdc_sync_bit u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retry_cnt <= retry_next;
      pll_rst   <= pll_rst_next;
      sys_rst_n <= sys_rst_n_next;
      locked    <= sys_rst_n_next;
      fail      <= fail_next;
      lock_lost <= lock_lost_next;
    end
  end

  always_comb begin
    state_next     = state;
    retry_next     = retry_cnt;
    lock_lost_next = 1'b0;
    restart        = 1'b0;

    if (soft_rst) begin
      // soft_rst wins, but a simultaneous lock loss in RUN is still reported
      state_next     = ST_RST;
      retry_next     = '0;
      restart        = 1'b1;
      lock_lost_next = (state == ST_RUN) && !lock_s;
    end else begin
      case (state)
        ST_RST: begin
          if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = ST_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_next = ST_FAIL;
            end else begin
              state_next = ST_RST;
              retry_next = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s) state_next = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next     = ST_RST;
            retry_next     = '0;
            lock_lost_next = 1'b1;
          end
        end
        ST_FAIL: state_next = ST_FAIL;
        default: state_next = ST_RST;
      endcase
    end

    // Counter saturates so a long stay in RUN or FAIL never wraps into a stale match
    if (restart || (state_next != state)) cnt_next = '0;
    else if (cnt == '1)                    cnt_next = cnt;
    else                                   cnt_next = cnt + CNT_W'(1);

    // Outputs are decoded from the next state so they register in step with it
    pll_rst_next   = (state_next == ST_RST) || (state_next == ST_FAIL);
    sys_rst_n_next = (state_next == ST_RUN);
    fail_next      = (state_next == ST_FAIL);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed segment table with hand-derived spot checks,
// then randomised lock/soft_rst/rst_n activity, every cycle compared to a reference model.
module tb_pll_lock_ctrl;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam logic [2:0] P_RST  = 3'd0;
  localparam logic [2:0] P_WAIT = 3'd1;
  localparam logic [2:0] P_STAB = 3'd2;
  localparam logic [2:0] P_RUN  = 3'd3;
  localparam logic [2:0] P_FAIL = 3'd4;

  // {state, pll_rst, sys_rst_n, locked, fail, lock_lost, retry_cnt}
  localparam logic [11:0] RST_OUT = 12'h100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst, sys_rst_n, locked, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  pll_lock_ctrl #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .soft_rst  (soft_rst),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .locked    (locked),
    .fail      (fail),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus the edge at which it was entered; lock is seen through
  // a two-edge delay line of pll_lock samples.
  logic [2:0] m_phase;
  int         m_entered;
  int         m_retry;
  bit         m_lost;
  bit         m_hist [2];

  function automatic logic [11:0] outs();
    return {state_dbg, pll_rst, sys_rst_n, locked, fail, lock_lost, retry_cnt};
  endfunction

  function automatic logic [11:0] model_out();
    logic [3:0] r;
    r = 4'(m_retry);
    return {m_phase, (m_phase == P_RST) || (m_phase == P_FAIL), m_phase == P_RUN,
            m_phase == P_RUN, m_phase == P_FAIL, m_lost, r};
  endfunction

  function automatic void enter(logic [2:0] p);
    m_phase   = p;
    m_entered = edge_no;
  endfunction

  function automatic void model_reset();
    m_phase   = P_RST;
    m_entered = edge_no;
    m_retry   = 0;
    m_lost    = 1'b0;
    m_hist    = '{1'b0, 1'b0};
  endfunction

  function automatic void model_step();
    bit ls;
    int dwell;
    ls        = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = pll_lock;
    dwell     = edge_no - m_entered;
    m_lost    = 1'b0;
    if (soft_rst) begin
      m_lost  = (m_phase == P_RUN) && !ls;
      m_retry = 0;
      enter(P_RST);
    end else begin
      case (m_phase)
        P_RST:  if (dwell >= RC) enter(P_WAIT);
        P_WAIT: begin
          if (ls) enter(P_STAB);
          else if (dwell >= LT) begin
            if (m_retry == MR) enter(P_FAIL);
            else begin
              m_retry = (m_retry < 15) ? m_retry + 1 : 15;
              enter(P_RST);
            end
          end
        end
        P_STAB: begin
          if (!ls) enter(P_WAIT);
          else if (dwell >= SC) enter(P_RUN);
        end
        P_RUN: begin
          if (!ls) begin
            m_lost  = 1'b1;
            m_retry = 0;
            enter(P_RST);
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%03h required=%03h (st|pll_rst|sys_rst_n|locked|fail|lock_lost|retry)",
               name, edge_no, act, exp);
    end
  endtask

  task automatic tick(bit lk, bit sr);
    @(negedge clk);
    pll_lock = lk;
    soft_rst = sr;
    @(posedge clk);
    edge_no++;
    if (rst_n) model_step();
    #1;
    check("cycle_model", outs(), model_out());
  endtask

  // Called just after a tick; asserts rst_n between edges.
  task automatic async_reset(int hold);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), RST_OUT);
    model_reset();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      edge_no++;
      #1 check("held_reset", outs(), RST_OUT);
    end
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         arst;
    bit         lk;
    bit         sr;
    int         n;
    logic [2:0] st;
    bit         prst;
    bit         srn;
    bit         fl;
    bit         ll;
    logic [3:0] rc;
  } seg_t;

  seg_t tbl[$];

  function automatic void add(bit arst, bit lk, bit sr, int n, logic [2:0] st,
                              bit prst, bit srn, bit fl, bit ll, logic [3:0] rc);
    seg_t s;
    s = '{arst, lk, sr, n, st, prst, srn, fl, ll, rc};
    tbl.push_back(s);
  endfunction

  initial begin
    // bring-up with lock at edge 10, RUN at edge 20
    add(0, 0, 0,   3, P_RST,  1, 0, 0, 0, 0);
    add(0, 0, 0,   1, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0,   5, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 1, 0,  10, P_STAB, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, P_RUN,  0, 1, 0, 0, 0);
    // lock drop in RUN
    add(0, 0, 0,   1, P_RUN,  0, 1, 0, 0, 0);
    add(0, 0, 0,   1, P_RUN,  0, 1, 0, 0, 0);
    add(0, 0, 0,   1, P_RST,  1, 0, 0, 1, 0);
    add(0, 1, 0,   1, P_RST,  1, 0, 0, 0, 0);
    add(0, 1, 0,   3, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 1, 0,   9, P_RUN,  0, 1, 0, 0, 0);
    // soft restart, then a 3-cycle glitch in STABLE
    add(0, 1, 1,   1, P_RST,  1, 0, 0, 0, 0);
    add(0, 1, 0,   5, P_STAB, 0, 0, 0, 0, 0);
    add(0, 0, 0,   3, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 1, 0,   2, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, P_STAB, 0, 0, 0, 0, 0);
    add(0, 1, 0,   7, P_STAB, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, P_RUN,  0, 1, 0, 0, 0);
    // soft_rst coinciding with lock_s fall in RUN
    add(0, 0, 0,   2, P_RUN,  0, 1, 0, 0, 0);
    add(0, 0, 1,   1, P_RST,  1, 0, 0, 1, 0);
    // lock never returns: two retries then FAIL
    add(0, 0, 0,   4, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0,  99, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 0, 0,   1, P_RST,  1, 0, 0, 0, 1);
    add(0, 0, 0, 103, P_WAIT, 0, 0, 0, 0, 1);
    add(0, 0, 0,   1, P_RST,  1, 0, 0, 0, 2);
    add(0, 0, 0, 103, P_WAIT, 0, 0, 0, 0, 2);
    add(0, 0, 0,   1, P_FAIL, 1, 0, 1, 0, 2);
    add(0, 0, 0,  20, P_FAIL, 1, 0, 1, 0, 2);
    add(0, 0, 1,   1, P_RST,  1, 0, 0, 0, 0);
    // rst_n pulse during STABLE reruns the full RST phase
    add(0, 1, 0,   6, P_STAB, 0, 0, 0, 0, 0);
    add(1, 1, 0,   3, P_RST,  1, 0, 0, 0, 0);
    add(0, 1, 0,   1, P_WAIT, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, P_STAB, 0, 0, 0, 0, 0);
    add(0, 1, 0,   8, P_RUN,  0, 1, 0, 0, 0);

    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      edge_no++;
      #1 check("por_reset", outs(), RST_OUT);
    end
    #1 rst_n = 1'b1;
    model_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].arst) async_reset(2);
      for (int i = 0; i < tbl[k].n; i++) tick(tbl[k].lk, tbl[k].sr && (i == 0));
      check($sformatf("seg%0d", k), outs(),
            {tbl[k].st, tbl[k].prst, tbl[k].srn, tbl[k].srn, tbl[k].fl, tbl[k].ll, tbl[k].rc});
    end

    for (int s = 0; s < 60; s++) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 130);
      if ($urandom_range(0, 19) == 0) async_reset($urandom_range(1, 3));
      for (int i = 0; i < len; i++) tick(lk, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
